// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter and the hazard logic that mirrors it.
package unified_mem_arbiter_pkg;

   // Arbiter FSM state encodings
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIfAcc  = 2'd1,
      StMemAcc = 2'd2
   } arb_state_e;

   // Which requester wins the grant in the current IDLE cycle
   typedef enum logic [1:0] {
      SelNone = 2'd0,
      SelIf   = 2'd1,
      SelMem  = 2'd2
   } req_sel_e;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_access_timer.sv
// Access timer: counts the cycles of one RAM access and flags its first and last cycle.
module access_timer
   import unified_mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,   // grant edge: reload the count to zero
   input  logic active,  // an access is in progress
   output logic first,
   output logic last
);

   localparam int unsigned CntW = cnt_width(MEM_LAT);
   localparam logic [CntW-1:0] LastVal = CntW'(MEM_LAT - 1);

   logic [CntW-1:0] lat_cnt_q, lat_cnt_d;

   // Next count: reload on grant, advance while busy, hold once the last cycle is reached
   always_comb begin
      lat_cnt_d = lat_cnt_q;
      if (start) begin
         lat_cnt_d = '0;
      end else if (active && !last) begin
         lat_cnt_d = lat_cnt_q + CntW'(1);
      end
   end

   // Latency counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt_q <= '0;
      end else begin
         lat_cnt_q <= lat_cnt_d;
      end
   end

   assign first = (lat_cnt_q == '0);
   assign last  = (lat_cnt_q == LastVal);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified-memory arbiter: shares one single-ported RAM between the IF and MEM pipeline stages.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

   arb_state_e         state_q, state_d;
   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
   req_sel_e           sel;
   logic               mem_req;
   logic               in_if, in_mem;
   logic               acc_first, acc_last;

   assign mem_req = mem_rd | mem_wr;
   assign in_if   = (state_q == StIfAcc);
   assign in_mem  = (state_q == StMemAcc);

   access_timer #(
      .MEM_LAT(MEM_LAT)
   ) u_access_timer (
      .clk   (clk),
      .rst   (rst),
      .start (sel != SelNone),
      .active(in_if | in_mem),
      .first (acc_first),
      .last  (acc_last)
   );

   // Grant decision, only in IDLE: MEM has priority until IF has waited STARVE_MAX grants
   always_comb begin
      sel = SelNone;
      if (state_q == StIdle) begin
         if (mem_req && (!if_req || (starve_cnt_q != StarveMax))) begin
            sel = SelMem;
         end else if (if_req) begin
            sel = SelIf;
         end
      end
   end

   // Next state: enter the granted access, return to IDLE after its last cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (sel == SelMem) begin
               state_d = StMemAcc;
            end else if (sel == SelIf) begin
               state_d = StIfAcc;
            end
         end
         StIfAcc, StMemAcc: begin
            if (acc_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Starvation count: MEM grants taken while IF waits; any cycle without if_req forgives it
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || (sel == SelIf)) begin
         starve_cnt_d = '0;
      end else if ((sel == SelMem) && (starve_cnt_q != StarveMax)) begin
         starve_cnt_d = starve_cnt_q + StarveW'(1);
      end
   end

   // State and starvation registers; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // RAM side and stage side outputs, decoded from the state; all zero outside an access
   always_comb begin
      ram_en    = in_if | in_mem;
      // rd and wr together count as a store; write only on the first cycle
      ram_we    = in_mem & mem_wr & acc_first;
      ram_addr  = '0;
      ram_wdata = '0;
      if (in_if) begin
         ram_addr = if_addr;
      end else if (in_mem) begin
         ram_addr  = mem_addr;
         ram_wdata = mem_wdata;
      end
      if_done   = in_if & acc_last;
      mem_done  = in_mem & acc_last;
      if_rdata  = if_done ? ram_rdata : '0;
      mem_rdata = mem_done ? ram_rdata : '0;
      stall_if  = if_req & ~if_done;
      stall_mem = mem_req & ~mem_done;
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: scoreboard of expected completions plus
// directed checks on reset, lone fetch, contention, stores, starvation and a MEM_LAT=1 build.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;

   // DUT with MEM_LAT=2
   logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
   logic [31:0] ram_rdata_q;
   logic        if_done, mem_done, stall_if, stall_mem, ram_en, ram_we;

   // DUT with MEM_LAT=1 (combinational RAM read)
   logic        mem_rd1 = 1'b0;
   logic [31:0] mem_addr1 = '0;
   logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
   logic        if_done1, mem_done1, stall_if1, stall_mem1, ram_en1, ram_we1;

   logic [31:0] ram [256];
   logic [31:0] ref_mem [256];

   typedef struct {
      string       tag;
      bit          is_mem;
      bit          is_store;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          exp1_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          mem_left = 0;
   int          we_cnt = 0;
   logic [31:0] we_addr, we_data;
   logic        en_s, we_s, ifd_s, memd_s, stall_if_s, stall_mem_s;
   logic [31:0] addr_s;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int i);
      return (i == 16) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
   endfunction

   // RAM model: one-cycle registered read, write on ram_we, contents restored on reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= pat(i);
      end else if (ram_en && ram_we) begin
         ram[ram_addr[9:2]] <= ram_wdata;
      end
      if (ram_en) ram_rdata_q <= ram[ram_addr[9:2]];
   end

   assign ram_rdata1 = ram[ram_addr1[9:2]];

   unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata_q)
   );

   unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
   ) dut1 (
      .clk(clk), .rst(rst),
      .if_req(1'b0), .if_addr(32'h0), .if_rdata(if_rdata1), .if_done(if_done1),
      .mem_rd(mem_rd1), .mem_wr(1'b0), .mem_addr(mem_addr1), .mem_wdata(32'h0),
      .mem_rdata(mem_rdata1), .mem_done(mem_done1),
      .stall_if(stall_if1), .stall_mem(stall_mem1),
      .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
      .ram_rdata(ram_rdata1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input string tag, input bit is_mem, input bit is_store,
                       input logic [31:0] data, input int c);
      exp_t e;
      e.tag = tag; e.is_mem = is_mem; e.is_store = is_store; e.data = data; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // One cycle: sample at negedge, score completions, then let requesters drop finished requests
   task automatic tick();
      exp_t e;
      @(negedge clk);
      en_s = ram_en; we_s = ram_we; addr_s = ram_addr;
      ifd_s = if_done; memd_s = mem_done; stall_if_s = stall_if; stall_mem_s = stall_mem;
      if (ram_we) begin
         we_cnt++;
         we_addr = ram_addr;
         we_data = ram_wdata;
      end
      if (if_done || mem_done) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", {30'b0, mem_done, if_done}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_who"}, {30'b0, mem_done, if_done}, e.is_mem ? 32'h2 : 32'h1);
            check_eq({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
            if (!e.is_store) check_eq({e.tag, "_data"}, mem_done ? mem_rdata : if_rdata, e.data);
         end
      end
      if (if_done) if_req = 1'b0;
      if (mem_done) begin
         if (mem_left > 0) mem_left--;
         if (mem_left == 0) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
         end
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
      tick();
   endtask

   initial begin
      int c;
      int ec;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

      // Reset state
      tick(); tick();
      check_eq("rst_en", {31'b0, en_s}, 32'h0);
      check_eq("rst_we", {31'b0, we_s}, 32'h0);
      check_eq("rst_done", {30'b0, ifd_s, memd_s}, 32'h0);
      check_eq("rst_addr", addr_s, 32'h0);
      rst = 1'b0;
      tick();

      // Reset in the middle of a MEM access: aborted, no done
      c = cyc; mem_rd = 1'b1; mem_addr = 32'h108; mem_left = 1;
      tick();
      check_eq("mid_rst_en_before", {31'b0, en_s}, 32'h1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_en", {31'b0, en_s}, 32'h0);
      check_eq("mid_rst_we", {31'b0, we_s}, 32'h0);
      check_eq("mid_rst_done", {30'b0, ifd_s, memd_s}, 32'h0);
      rst = 1'b0; mem_rd = 1'b0; mem_left = 0;
      repeat (4) tick();

      // Lone fetch from 0x40
      c = cyc; if_req = 1'b1; if_addr = 32'h40;
      push("fetch", 1'b0, 1'b0, ref_mem[16], c + 2);
      tick();
      check_eq("fetch_en1", {31'b0, en_s}, 32'h1);
      check_eq("fetch_addr", addr_s, 32'h40);
      check_eq("fetch_stall1", {31'b0, stall_if_s}, 32'h1);
      tick();
      check_eq("fetch_en2", {31'b0, en_s}, 32'h1);
      check_eq("fetch_stall2", {31'b0, stall_if_s}, 32'h0);
      tick();
      check_eq("fetch_en3", {31'b0, en_s}, 32'h0);
      check_eq("idle_addr", addr_s, 32'h0);
      drain("fetch");

      // Contention: MEM first, IF after one IDLE cycle
      c = cyc; if_req = 1'b1; if_addr = 32'h44; mem_rd = 1'b1; mem_addr = 32'h100; mem_left = 1;
      push("cont_mem", 1'b1, 1'b0, ref_mem[8'h40], c + 2);
      push("cont_if", 1'b0, 1'b0, ref_mem[8'h11], c + 5);
      drain("cont");

      // Store, then read back
      c = cyc; we_cnt = 0; mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
      mem_left = 1; ref_mem[8] = 32'hDEAD_BEEF;
      push("store", 1'b1, 1'b1, 32'h0, c + 2);
      drain("store");
      check_eq("store_we_cnt", 32'(we_cnt), 32'h1);
      check_eq("store_we_addr", we_addr, 32'h20);
      check_eq("store_we_data", we_data, 32'hDEAD_BEEF);
      c = cyc; mem_rd = 1'b1; mem_addr = 32'h20; mem_left = 1;
      push("load_back", 1'b1, 1'b0, ref_mem[8], c + 2);
      drain("load_back");

      // rd and wr together behave as a store
      c = cyc; we_cnt = 0; mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h24;
      mem_wdata = 32'h1234_5678; mem_left = 1; ref_mem[9] = 32'h1234_5678;
      push("rdwr", 1'b1, 1'b1, 32'h0, c + 2);
      drain("rdwr");
      check_eq("rdwr_we_cnt", 32'(we_cnt), 32'h1);
      c = cyc; mem_rd = 1'b1; mem_addr = 32'h24; mem_left = 1;
      push("rdwr_back", 1'b1, 1'b0, ref_mem[9], c + 2);
      drain("rdwr_back");

      // Starvation: four MEM grants, then IF, then MEM again
      c = cyc; if_req = 1'b1; if_addr = 32'h48; mem_rd = 1'b1; mem_addr = 32'h104; mem_left = 5;
      for (int k = 0; k < 4; k++) push("starve_mem", 1'b1, 1'b0, ref_mem[8'h41], c + 2 + 3 * k);
      push("starve_if", 1'b0, 1'b0, ref_mem[8'h12], c + 14);
      push("starve_mem5", 1'b1, 1'b0, ref_mem[8'h41], c + 17);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         tick();
         if (cyc == c + 12) check_eq("starve_cnt_max", 32'(dut.starve_cnt_q), 32'h4);
         if (cyc == c + 13) check_eq("starve_cnt_clr", 32'(dut.starve_cnt_q), 32'h0);
      end
      check_eq("starve_drain", 32'(exp_q.size()), 32'h0);
      tick();

      // MEM_LAT=1 build: done in the first ACC cycle, grants two cycles apart
      c = cyc; mem_rd1 = 1'b1; mem_addr1 = 32'h40;
      exp1_q.push_back(c + 1);
      exp1_q.push_back(c + 3);
      for (int i = 0; i < 12 && exp1_q.size() != 0; i++) begin
         tick();
         if (mem_done1) begin
            ec = exp1_q.pop_front();
            check_eq("lat1_cyc", 32'(cyc), 32'(ec));
            check_eq("lat1_data", mem_rdata1, pat(16));
            if (exp1_q.size() == 0) mem_rd1 = 1'b0;
         end
      end
      check_eq("lat1_drain", 32'(exp1_q.size()), 32'h0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
